// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Status/Cause/EPC with exception update, PRId/Config constants.
// Define CP0_TIMER_EN to build the Count/Compare timer and timer interrupt; otherwise they read 0.
module cp0_reg #(
    parameter logic [31:0] PRID_VAL   = 32'h00480102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000,
    parameter logic [31:0] STATUS_RST = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;
    localparam logic [4:0] ADDR_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_INT     = 32'h00000001;
    localparam logic [31:0] EXC_SYSCALL = 32'h00000008;
    localparam logic [31:0] EXC_INVINST = 32'h0000000a;
    localparam logic [31:0] EXC_OV      = 32'h0000000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000000e;

    logic [31:0] status_q, cause_q, epc_q;
    logic [31:0] status_nx, cause_nx, epc_nx;
    logic [31:0] victim_pc;

    assign prid_o   = PRID_VAL;
    assign config_o = CONFIG_VAL;
    assign status_o = status_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;

    assign victim_pc = is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;

    // MTC0 first, then the exception overlays its fields on top.
    always_comb begin
        status_nx = status_q;
        cause_nx  = cause_q;
        epc_nx    = epc_q;
        cause_nx[15:10] = int_i;

        if (we_i) begin
            case (waddr_i)
                ADDR_STATUS: status_nx = data_i;
                ADDR_CAUSE: begin
                    cause_nx[9:8] = data_i[9:8];
                    cause_nx[23]  = data_i[23];
                    cause_nx[22]  = data_i[22];
                end
                ADDR_EPC: epc_nx = data_i;
                default: ;
            endcase
        end

        case (excepttype_i)
            EXC_INT: begin
                epc_nx        = victim_pc;
                cause_nx[31]  = is_in_delayslot_i;
                status_nx[1]  = 1'b1;
                cause_nx[6:2] = 5'd0;
            end
            EXC_SYSCALL, EXC_INVINST, EXC_TRAP, EXC_OV: begin
                // A nested exception (EXL already set) keeps the original EPC/BD.
                if (!status_q[1]) begin
                    epc_nx       = victim_pc;
                    cause_nx[31] = is_in_delayslot_i;
                end
                status_nx[1]  = 1'b1;
                cause_nx[6:2] = excepttype_i[4:0];
            end
            EXC_ERET: status_nx[1] = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= STATUS_RST;
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
        end else begin
            status_q <= status_nx;
            cause_q  <= cause_nx;
            epc_q    <= epc_nx;
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, compare_q;
    logic        timer_int_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            timer_int_q <= 1'b0;
        end else begin
            if (we_i && waddr_i == ADDR_COUNT)
                count_q <= data_i;
            else
                count_q <= count_q + 32'd1;

            // Compare write clears the sticky interrupt and beats a coincident match.
            if (we_i && waddr_i == ADDR_COMPARE) begin
                compare_q   <= data_i;
                timer_int_q <= 1'b0;
            end else if (compare_q != 32'd0 && count_q == compare_q) begin
                timer_int_q <= 1'b1;
            end
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;
`else
    assign count_o     = 32'd0;
    assign compare_o   = 32'd0;
    assign timer_int_o = 1'b0;
`endif

    always_comb begin
        data_o = 32'd0;
        if (rst) begin
            case (raddr_i)
                ADDR_COUNT:   data_o = count_o;
                ADDR_COMPARE: data_o = compare_o;
                ADDR_STATUS:  data_o = status_q;
                ADDR_CAUSE:   data_o = cause_q;
                ADDR_EPC:     data_o = epc_q;
                ADDR_PRID:    data_o = PRID_VAL;
                ADDR_CONFIG:  data_o = CONFIG_VAL;
                default:      data_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg; timer checks adapt to whether CP0_TIMER_EN is defined.
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i, raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i, current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cp0_reg dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .int_i(int_i), .excepttype_i(excepttype_i),
        .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
        .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
        .timer_int_o(timer_int_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0;
        excepttype_i = 32'd0; current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; data_i = d;
        tick();
        idle_inputs();
    endtask

    task automatic raise(input logic [31:0] code, input logic [31:0] pc, input logic ds);
        excepttype_i = code; current_inst_addr_i = pc; is_in_delayslot_i = ds;
        tick();
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0; raddr_i = 5'd12; int_i = 6'd0;
        idle_inputs();
        repeat (3) tick();
        check("rst_status", status_o, 32'h10000000);
        check("rst_epc", epc_o, 32'd0);
        check("rst_cause", cause_o, 32'd0);
        check("rst_timer", {31'd0, timer_int_o}, 32'd0);
        check("rst_count", count_o, 32'd0);
        check("rst_data_o", data_o, 32'd0);
        check("prid", prid_o, 32'h00480102);
        check("config", config_o, 32'h00008000);

        rst = 1'b1;
        tick();
`ifdef CP0_TIMER_EN
        check("count_first", count_o, 32'd1);
        tick();
        check("count_second", count_o, 32'd2);
        mtc0(5'd9, 32'hFFFFFFFF);
        check("count_load", count_o, 32'hFFFFFFFF);
        tick();
        check("count_wrap", count_o, 32'd0);
`else
        check("count_off", count_o, 32'd0);
        tick();
        check("count_off2", count_o, 32'd0);
`endif

        raddr_i = 5'd12; #1 check("rd_status", data_o, 32'h10000000);
        raddr_i = 5'd15; #1 check("rd_prid", data_o, 32'h00480102);
        raddr_i = 5'd16; #1 check("rd_config", data_o, 32'h00008000);
        raddr_i = 5'd20; #1 check("rd_unmapped", data_o, 32'd0);
        mtc0(5'd15, 32'hFFFFFFFF);
        mtc0(5'd16, 32'h0);
        raddr_i = 5'd15; #1 check("prid_ro", data_o, 32'h00480102);
        raddr_i = 5'd16; #1 check("config_ro", data_o, 32'h00008000);

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd10);
        check("timer_count10", count_o, 32'd10);
        for (int k = 1; k <= 11; k++) begin
            tick();
            check($sformatf("timer_c%0d", k), {31'd0, timer_int_o}, {31'd0, k == 11});
        end
        repeat (3) tick();
        check("timer_sticky", {31'd0, timer_int_o}, 32'd1);
        mtc0(5'd11, 32'd5);
        check("timer_clear", {31'd0, timer_int_o}, 32'd0);
        check("compare_val", compare_o, 32'd5);
        raddr_i = 5'd11; #1 check("rd_compare", data_o, 32'd5);
`else
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd10);
        check("compare_off", compare_o, 32'd0);
        raddr_i = 5'd11; #1 check("rd_compare_off", data_o, 32'd0);
        raddr_i = 5'd9;  #1 check("rd_count_off", data_o, 32'd0);
        repeat (15) tick();
        check("timer_off", {31'd0, timer_int_o}, 32'd0);
`endif

        mtc0(5'd13, 32'hFFFFFFFF);
        check("cause_wmask", cause_o, 32'h00C00300);
        mtc0(5'd13, 32'h0);
        check("cause_wclr", cause_o, 32'd0);

        raise(32'h8, 32'h00000104, 1'b1);
        check("sys_epc", epc_o, 32'h00000100);
        check("sys_cause", cause_o, 32'h80000020);
        check("sys_status", status_o, 32'h10000002);

        raise(32'hc, 32'h00000200, 1'b0);
        check("nest_epc", epc_o, 32'h00000100);
        check("nest_cause", cause_o, 32'h80000030);

        raise(32'he, 32'h0, 1'b0);
        check("eret_status", status_o, 32'h10000000);
        check("eret_epc", epc_o, 32'h00000100);

        raise(32'h5, 32'h00000500, 1'b1);
        check("unk_epc", epc_o, 32'h00000100);
        check("unk_status", status_o, 32'h10000000);
        check("unk_cause", cause_o, 32'h80000030);

        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'hDEAD0000;
        int_i = 6'b000001;
        raise(32'h1, 32'h00000300, 1'b0);
        int_i = 6'd0;
        check("coll_epc", epc_o, 32'h00000300);
        check("coll_cause", cause_o, 32'h00000400);
        check("coll_status", status_o, 32'h10000002);
        tick();
        check("ip_drop", cause_o, 32'd0);

        raise(32'h1, 32'h00000400, 1'b1);
        check("int_ds_epc", epc_o, 32'h000003FC);
        check("int_ds_cause", cause_o, 32'h80000000);

        mtc0(5'd14, 32'h00001234);
        mtc0(5'd12, 32'h0000FF01);
        raddr_i = 5'd14; #1 check("rd_epc", data_o, 32'h00001234);
        check("status_w", status_o, 32'h0000FF01);

        // Reset asserted between clock edges must act immediately.
        rst = 1'b0;
        #1;
        check("arst_status", status_o, 32'h10000000);
        check("arst_epc", epc_o, 32'd0);
        check("arst_cause", cause_o, 32'd0);
        check("arst_data_o", data_o, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
Coprocessor-0 register file for the STPU pipeline. Takes the committed exception type and instruction address from the MEM stage and updates Status, Cause and EPC. Feeds `epc_o` to the pipeline controller's `cp0_epc_i` for ERET redirection. Also runs the Count/Compare timer and raises a timer interrupt.

Parameters:
- PRID_VAL, 32'h00480102: read-only Processor ID value.
- CONFIG_VAL, 32'h00008000: read-only Config value (BE=1).
- STATUS_RST, 32'h10000000: Status reset value (CU0=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (rst==0 resets)
- we_i  in  1  CP0 write enable (MTC0 at WB)
- waddr_i  in  5  write register number
- raddr_i  in  5  read register number (MFC0)
- data_i  in  32  write data
- int_i  in  6  external hardware interrupt lines
- excepttype_i  in  32  committed exception code; 0 = none
- current_inst_addr_i  in  32  PC of excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a delay slot
- data_o  out  32  read data for raddr_i
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  register views
- timer_int_o  out  1  timer interrupt request

Behaviour:
- Registers and addresses:
  - Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16.
  - Any other address reads 0; writes to it are ignored.
- Reset (async, rst==0):
  - count/compare/cause/epc = 0.
  - status = STATUS_RST.
  - prid_o = PRID_VAL, config_o = CONFIG_VAL.
  - timer_int_o = 0, data_o = 0.
- All updates occur on posedge clk while rst==1.
- Count: increments by 1 every cycle and wraps 32'hFFFFFFFF -> 0.
  - A write to Count loads data_i instead of incrementing that cycle.
- Timer interrupt:
  - timer_int_o is set to 1 on the cycle after count==compare with compare!=0.
  - It stays set (sticky) until Compare is written.
  - A Compare write loads compare and clears timer_int_o in the same edge; the clear wins over a simultaneous match.
- Cause:
  - cause[15:10] <= int_i every cycle (sampled, 1-cycle latency).
  - Writable by MTC0: cause[9:8] (software IP), cause[23] (IV), cause[22] (WP).
  - All other bits are written only by exceptions.
- Status: fully writable by MTC0.
- EPC: fully writable by MTC0.
- PRId and Config: read-only; writes are ignored.
- Read path: data_o is combinational from the current register state.
  - No same-cycle write bypass; forwarding is the EX stage's job.
- Exception update (excepttype_i != 0), applied after any same-cycle MTC0 write, so exception fields override it:
  - 0x00000001 (interrupt):
    - epc <= is_in_delayslot_i ? current_inst_addr_i-4 : current_inst_addr_i.
    - cause[31] <= is_in_delayslot_i.
    - status[1] (EXL) <= 1.
    - cause[6:2] <= 0.
  - 0x00000008 syscall, 0x0000000a invalid inst, 0x0000000d trap, 0x0000000c overflow:
    - If status[1]==0: update epc and cause[31] as for interrupt.
    - Always: status[1] <= 1.
    - cause[6:2] <= 8, 10, 13, 12 respectively.
  - 0x0000000e (eret): status[1] <= 0. EPC is unchanged.
  - Any other nonzero code: no register change.
- Count and cause IP sampling continue during exception cycles.
- Mid-operation reset: all state returns to reset values immediately, independent of clk.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count/Compare and timer_int_o behave as above.
- Undefined:
  - Count and Compare registers are removed.
  - count_o and compare_o read 0.
  - Reads of addresses 9 and 11 return 0; writes to them are ignored.
  - timer_int_o is tied to 0.

Test Plan:
- Reset: hold rst=0, toggle clk -> status_o=32'h10000000, epc_o=0, timer_int_o=0. Release rst -> count_o=1 after the first edge, 2 after the second.
- Timer: write Compare=20, Count=10 -> timer_int_o=1 eleven cycles after the Count write. Stays 1 until a Compare write, which drops it to 0 at the same edge.
- Syscall in delay slot: status[1]=0, excepttype_i=8, addr=32'h00000104, delayslot=1 -> epc_o=32'h00000100, cause[31]=1, cause[6:2]=8, status[1]=1.
- Nested exception: status[1]=1, excepttype_i=0xc, addr=32'h200 -> epc_o unchanged, cause[6:2]=12.
- ERET: after the syscall case, excepttype_i=0xe -> status[1]=0, epc_o still 32'h00000100.
- Write/exception collision: same cycle we_i=1, waddr_i=14, data_i=32'hDEAD0000, excepttype_i=1, addr=32'h300, delayslot=0 -> epc_o=32'h300. Also int_i=6'b000001 -> cause[10]=1 one cycle later.
